audio_shift_normalizer: RTL
===========================

// Module: audio_shift_normalizer
// PURPOSE
//  Downstream of audio_min_max. After its done pulse, takes out_max/out_min, derives a
//  power-of-two gain (left shift) that brings the block's peak as close to full scale as
//  possible without overflow, then replays the N buffered samples through a read port and
//  streams them out scaled with a valid/ready handshake. Pulses d when the block is emitted.
// PARAMETERS
//  N          100  samples per block (same N as the min/max stage)
//  W          32   signed sample width
//  MAX_SHIFT  15   upper bound on applied shift (caps gain on near-silent blocks)
//  AW         7    sample-buffer address width, 2**AW >= N
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  start       in   1   1-cycle pulse; in_max/in_min valid in the same cycle
//  in_max      in   W   signed block maximum (from min/max stage out_max)
//  in_min      in   W   signed block minimum (from min/max stage out_min)
//  rd_en       out  1   sample-buffer read strobe
//  rd_addr     out  AW  sample index 0..N-1
//  rd_data     in   W   signed sample; valid exactly 1 cycle after rd_en
//  out_sample  out  W   scaled sample = rd_data <<< shift_amt
//  out_valid   out  1   out_sample valid; held until out_ready
//  out_ready   in   1   consumer accepts when out_valid && out_ready
//  out_last    out  1   high with the beat carrying sample N-1
//  shift_amt   out  4   applied shift, stable from end of CALC until next start
//  busy        out  1   high in every state except IDLE
//  d           out  1   1-cycle done pulse after last beat accepted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (out_sample, shift_amt, rd_addr included).
//  FSM: IDLE -> PEAK -> CALC -> FETCH -> WAIT -> OUT -> (FETCH | DONE) -> IDLE.
//  IDLE: start=1 latches in_max/in_min; go PEAK. start outside IDLE ignored.
//  PEAK (1 cyc): peak = max(in_max, -in_min) computed in W+1 bits (in_min=-2^(W-1)
//    gives peak=2^(W-1)); negative in_max treated via the max, peak never negative.
//    shift_amt <= 0; go CALC.
//  CALC: 1 compare per cycle: if shift_amt<MAX_SHIFT and peak!=0 and
//    (peak << (shift_amt+1)) <= 2^(W-1)-1 (compared in W+MAX_SHIFT+1 bits) then
//    shift_amt++ and stay; else go FETCH with rd_addr=0. Latency 1..MAX_SHIFT+1 cycles.
//    peak=0 or peak>=2^(W-1) -> shift 0.
//  FETCH (1 cyc): rd_en=1 for current rd_addr; go WAIT.
//  WAIT (1 cyc): capture rd_data, out_sample <= rd_data <<< shift_amt (arith, W bits,
//    guaranteed no overflow by CALC); out_valid<=1; out_last<=(rd_addr==N-1); go OUT.
//  OUT: hold out_sample/out_valid/out_last stable while out_ready=0. On accept:
//    out_valid<=0; if last -> DONE else rd_addr++ and -> FETCH. Throughput <= 1/3 beat/cyc.
//  DONE (1 cyc): d=1, busy=0 next cycle; shift_amt retained; go IDLE.
//  rd_en is 1 only in FETCH; rd_addr never exceeds N-1 (no wrap).
//  Async reset mid-block: immediate return to IDLE, outputs cleared, no d pulse;
//    partial stream is abandoned, next start restarts from sample 0.
//  out_ready high while out_valid low has no effect.
// TESTING
//  1 Min/max stage's 100-sample block, max=458752, min=-1769472 -> shift_amt=10,
//    beat0=201326592, beat97=-1811939328, out_last on beat 99 only, then d for 1 cycle.
//  2 in_max=0,in_min=0 (silence) -> shift_amt=0, 100 beats equal to rd_data, d pulses.
//  3 in_min=-2^31,in_max=5 -> shift_amt=0; in_max=1,in_min=0 -> shift_amt=15 (cap).
//  4 out_ready random 30% duty -> out_sample/out_valid/out_last stable while stalled;
//    exactly 100 accepted beats in order, no duplicates or drops, rd_en count=100.
//  5 Assert reset during beat 40 -> all outputs 0 same cycle, no d; new start replays
//    from rd_addr=0 with correct shift.
//  6 start pulsed while busy -> ignored (latched max/min and stream unchanged).

Source files
------------

// File: rtl/audio_shift_normalizer.sv
// ---------------------------------------------------------------------------
// audio_shift_normalizer
//
// Sits after the block min/max stage. When that stage reports a block's
// extremes it picks the largest power-of-two gain (left shift, capped at
// MAX_SHIFT) that keeps the block peak within signed full scale. It then
// reads the N buffered samples back through a one-cycle-latency read port
// and streams them out scaled, using a valid/ready handshake.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   start      : 1-cycle pulse, in_max/in_min valid in the same cycle
//   in_max     : signed block maximum
//   in_min     : signed block minimum
//   rd_en      : sample-buffer read strobe (high only in FETCH)
//   rd_addr    : sample index 0..N-1
//   rd_data    : signed sample, valid one cycle after rd_en
//   out_sample : rd_data <<< shift_amt
//   out_valid  : out_sample valid, held until out_ready
//   out_ready  : consumer accepts when out_valid && out_ready
//   out_last   : marks the beat carrying sample N-1
//   shift_amt  : applied shift, stable from end of CALC until next start
//   busy       : high in every state except IDLE
//   d          : 1-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module audio_shift_normalizer #(
    parameter int N         = 100,
    parameter int W         = 32,
    parameter int MAX_SHIFT = 15,
    parameter int AW        = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  in_max,
    input  logic [W-1:0]  in_min,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data,
    output logic [W-1:0]  out_sample,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [3:0]    shift_amt,
    output logic          busy,
    output logic          d
);

    // Width of the gain trial compare: a W+1 bit peak shifted by up to
    // MAX_SHIFT must never lose bits before it is compared.
    localparam int CW = W + MAX_SHIFT + 1;

    // 2^(W-1)-1, the largest positive sample, zero-extended to CW bits.
    localparam logic [CW-1:0] FULL_SCALE = {{(CW-W+1){1'b0}}, {(W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEAK,
        S_CALC,
        S_FETCH,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic signed [W-1:0] max_q, max_d;
    logic signed [W-1:0] min_q, min_d;
    logic        [W:0]   peak_q, peak_d;
    logic        [3:0]   shift_q, shift_d;
    logic        [AW-1:0] addr_q, addr_d;
    logic signed [W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    // Magnitude of the block peak in W+1 bits so that the most negative
    // input (-2^(W-1)) maps to +2^(W-1) without wrapping. Clamped at zero
    // so a malformed max/min pair can never produce a negative peak.
    function automatic logic [W:0] peak_of(input logic signed [W-1:0] mx,
                                           input logic signed [W-1:0] mn);
        logic signed [W:0] mx_e;
        logic signed [W:0] neg_mn;
        logic signed [W:0] pk;
        mx_e   = {mx[W-1], mx};
        neg_mn = -{mn[W-1], mn};
        pk     = (mx_e > neg_mn) ? mx_e : neg_mn;
        if (pk[W]) begin
            pk = '0;
        end
        return pk;
    endfunction

    // True when the peak shifted by one more than the current gain still
    // fits in signed full scale.
    function automatic logic gain_fits(input logic [W:0] pk,
                                       input logic [3:0] s);
        logic [CW-1:0] wide;
        wide = CW'(pk) << ({1'b0, s} + 5'd1);
        return (wide <= FULL_SCALE);
    endfunction

    // Arithmetic gain. CALC guarantees the result does not overflow W bits
    // for any sample inside the block's reported min/max range.
    function automatic logic signed [W-1:0] scale(input logic signed [W-1:0] x,
                                                  input logic [3:0]          s);
        return x <<< s;
    endfunction

    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        min_d    = min_q;
        peak_d   = peak_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        last_d   = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    max_d   = in_max;
                    min_d   = in_min;
                    state_d = S_PEAK;
                end
            end

            S_PEAK: begin
                peak_d  = peak_of(max_q, min_q);
                shift_d = '0;
                state_d = S_CALC;
            end

            // One trial shift per cycle; stops at the first gain that would
            // overflow, at the cap, or immediately for a silent block.
            S_CALC: begin
                if ((shift_q < 4'(MAX_SHIFT)) && (peak_q != '0) &&
                    gain_fits(peak_q, shift_q)) begin
                    shift_d = shift_q + 4'd1;
                end else begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                sample_d = scale($signed(rd_data), shift_q);
                valid_d  = 1'b1;
                last_d   = (addr_q == AW'(N - 1));
                state_d  = S_OUT;
            end

            // Beat is held untouched until the consumer takes it.
            S_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            max_q    <= '0;
            min_q    <= '0;
            peak_q   <= '0;
            shift_q  <= '0;
            addr_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            min_q    <= min_d;
            peak_q   <= peak_d;
            shift_q  <= shift_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Strobes decoded straight from the state so an asynchronous reset
    // clears them in the same cycle.
    assign rd_en      = (state_q == S_FETCH);
    assign busy       = (state_q != S_IDLE);
    assign d          = (state_q == S_DONE);
    assign rd_addr    = addr_q;
    assign out_sample = sample_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign shift_amt  = shift_q;

endmodule
